// File: rtl/jt12_mod_seq_if.sv
// Bus bundle for jt12_mod_seq: operator-pipeline handshake, config writes and channel-sum output.
`default_nettype none

interface jt12_mod_seq_if #(
    parameter int CHW = 3,
    parameter int W   = 14
);
    logic                  cen;
    logic                  cfg_we;
    logic [CHW-1:0]        cfg_ch;
    logic [2:0]            cfg_alg;
    logic [2:0]            cfg_fb;
    logic signed [W-1:0]   op_out;
    logic signed [W:0]     mod_out;
    logic [1:0]            mod_op;
    logic [CHW-1:0]        mod_ch;
    logic                  mod_valid;
    logic                  frame_sync;
    logic signed [W+1:0]   ch_sum;
    logic [CHW-1:0]        ch_sum_ch;
    logic                  ch_sum_valid;

    modport master (
        output cen, cfg_we, cfg_ch, cfg_alg, cfg_fb, op_out,
        input  mod_out, mod_op, mod_ch, mod_valid, frame_sync,
               ch_sum, ch_sum_ch, ch_sum_valid
    );

    modport slave (
        input  cen, cfg_we, cfg_ch, cfg_alg, cfg_fb, op_out,
        output mod_out, mod_op, mod_ch, mod_valid, frame_sync,
               ch_sum, ch_sum_ch, ch_sum_valid
    );
endinterface

`default_nettype wire

// File: rtl/jt12_mod_seq.sv
// Slot sequencer and modulation router for CH channels x 4 FM operators:
// holds operator history, builds per-slot modulation and sums carriers per channel.
`default_nettype none

module jt12_mod_seq #(
    parameter int CH    = 6,
    parameter int CHW   = 3,
    parameter int W     = 14,
    parameter int OPLAT = 1,
    parameter int FBMAX = 9
) (
    input  logic           clk,
    input  logic           rst,
    jt12_mod_seq_if.slave  bus
);
    localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);

    logic [1:0]           op_q, op_d;
    logic [CHW-1:0]       ch_q, ch_d;
    logic [2:0]           alg_q    [CH];
    logic [2:0]           alg_sh_q [CH];
    logic [2:0]           fb_sh_q  [CH];
    logic signed [W-1:0]  o1_q     [CH];
    logic signed [W-1:0]  o1_old_q [CH];
    logic signed [W-1:0]  o2_q     [CH];
    logic signed [W-1:0]  o3_q     [CH];
    logic signed [W+1:0]  acc_q    [CH];

    // tag[0] is the slot currently presented; tag[OPLAT-1] owns the incoming op_out
    logic [1:0]           tag_op_q [OPLAT];
    logic [CHW-1:0]       tag_ch_q [OPLAT];
    logic                 tag_v_q  [OPLAT];

    logic signed [W:0]    mod_out_q, mod_d;
    logic                 frame_sync_q;
    logic signed [W+1:0]  ch_sum_q, acc_d;
    logic [CHW-1:0]       ch_sum_ch_q;
    logic                 ch_sum_valid_q;

    logic [2:0]           cur_alg, cur_fb, wb_alg;
    logic [4:0]           fb_shift;
    logic signed [W:0]    o1x, o1ox, o2x, o3x, fb_sum;
    logic                 wb_v, wb_car;
    logic [1:0]           wb_op;
    logic [CHW-1:0]       wb_ch;
    logic signed [W+1:0]  op_x;

    always_comb begin
        op_d = op_q;
        ch_d = ch_q + 1'b1;
        if (ch_q == LAST_CH) begin
            ch_d = '0;
            op_d = op_q + 2'd1;
        end
    end

    // Feedback is read from the shadow: op1 presentation is exactly when it becomes active.
    always_comb begin
        cur_alg  = alg_q[ch_q];
        cur_fb   = fb_sh_q[ch_q];
        o1x      = {o1_q[ch_q][W-1], o1_q[ch_q]};
        o1ox     = {o1_old_q[ch_q][W-1], o1_old_q[ch_q]};
        o2x      = {o2_q[ch_q][W-1], o2_q[ch_q]};
        o3x      = {o3_q[ch_q][W-1], o3_q[ch_q]};
        fb_sum   = o1x + o1ox;
        fb_shift = 5'(FBMAX) - {2'b00, cur_fb};
        mod_d    = '0;
        case (op_q)
            2'd0: if (cur_fb != 3'd0) mod_d = fb_sum >>> fb_shift;
            2'd1: if (cur_alg inside {3'd0, 3'd3, 3'd4, 3'd5, 3'd6}) mod_d = o1x;
            2'd2: begin
                case (cur_alg)
                    3'd0, 3'd2: mod_d = o2x;
                    3'd1:       mod_d = o1x + o2x;
                    3'd5:       mod_d = o1x;
                    default:    mod_d = '0;
                endcase
            end
            default: begin
                case (cur_alg)
                    3'd0, 3'd1, 3'd4: mod_d = o3x;
                    3'd2:             mod_d = o1x + o3x;
                    3'd3:             mod_d = o2x + o3x;
                    3'd5:             mod_d = o1x;
                    default:          mod_d = '0;
                endcase
            end
        endcase
    end

    always_comb begin
        wb_v   = tag_v_q[OPLAT-1];
        wb_op  = tag_op_q[OPLAT-1];
        wb_ch  = tag_ch_q[OPLAT-1];
        wb_alg = alg_q[wb_ch];
        wb_car = (wb_op == 2'd3) ||
                 (wb_op == 2'd2 && wb_alg >= 3'd5) ||
                 (wb_op == 2'd1 && wb_alg >= 3'd4) ||
                 (wb_op == 2'd0 && wb_alg == 3'd7);
        op_x   = {{2{bus.op_out[W-1]}}, bus.op_out};
        acc_d  = ((wb_op == 2'd0) ? '0 : acc_q[wb_ch]) + (wb_car ? op_x : '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q           <= '0;
            ch_q           <= '0;
            mod_out_q      <= '0;
            frame_sync_q   <= 1'b0;
            ch_sum_q       <= '0;
            ch_sum_ch_q    <= '0;
            ch_sum_valid_q <= 1'b0;
            for (int i = 0; i < OPLAT; i++) begin
                tag_op_q[i] <= '0;
                tag_ch_q[i] <= '0;
                tag_v_q[i]  <= 1'b0;
            end
            for (int i = 0; i < CH; i++) begin
                alg_q[i]    <= '0;
                alg_sh_q[i] <= '0;
                fb_sh_q[i]  <= '0;
                o1_q[i]     <= '0;
                o1_old_q[i] <= '0;
                o2_q[i]     <= '0;
                o3_q[i]     <= '0;
                acc_q[i]    <= '0;
            end
        end else if (bus.cen) begin
            op_q         <= op_d;
            ch_q         <= ch_d;
            mod_out_q    <= mod_d;
            frame_sync_q <= (op_q == 2'd0) && (ch_q == '0);
            tag_op_q[0]  <= op_q;
            tag_ch_q[0]  <= ch_q;
            tag_v_q[0]   <= 1'b1;
            for (int i = 1; i < OPLAT; i++) begin
                tag_op_q[i] <= tag_op_q[i-1];
                tag_ch_q[i] <= tag_ch_q[i-1];
                tag_v_q[i]  <= tag_v_q[i-1];
            end

            // Non-blocking: a write landing on the latch cycle applies from the next sample.
            if (op_q == 2'd0)
                alg_q[ch_q] <= alg_sh_q[ch_q];
            if (bus.cfg_we && (int'(bus.cfg_ch) < CH)) begin
                alg_sh_q[bus.cfg_ch] <= bus.cfg_alg;
                fb_sh_q[bus.cfg_ch]  <= bus.cfg_fb;
            end

            if (wb_v) begin
                acc_q[wb_ch] <= acc_d;
                case (wb_op)
                    2'd0: begin
                        o1_q[wb_ch]     <= bus.op_out;
                        o1_old_q[wb_ch] <= o1_q[wb_ch];
                    end
                    2'd1: o2_q[wb_ch] <= bus.op_out;
                    2'd2: o3_q[wb_ch] <= bus.op_out;
                    default: begin
                        ch_sum_q    <= acc_d;
                        ch_sum_ch_q <= wb_ch;
                    end
                endcase
            end
            ch_sum_valid_q <= wb_v && (wb_op == 2'd3);
        end
    end

    assign bus.mod_out      = mod_out_q;
    assign bus.mod_op       = tag_op_q[0];
    assign bus.mod_ch       = tag_ch_q[0];
    assign bus.mod_valid    = tag_v_q[0];
    assign bus.frame_sync   = frame_sync_q;
    assign bus.ch_sum       = ch_sum_q;
    assign bus.ch_sum_ch    = ch_sum_ch_q;
    assign bus.ch_sum_valid = ch_sum_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_jt12_mod_seq.sv
// Directed bench for jt12_mod_seq: schedule, algorithm routing, feedback, config timing, cen gating, reset.
`default_nettype none

module tb_jt12_mod_seq;
    localparam int CH    = 6;
    localparam int CHW   = 3;
    localparam int W     = 14;
    localparam int OPLAT = 1;
    localparam int FBMAX = 9;
    localparam int N     = 4 * CH;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    jt12_mod_seq_if #(.CHW(CHW), .W(W)) bus ();

    jt12_mod_seq #(.CH(CH), .CHW(CHW), .W(W), .OPLAT(OPLAT), .FBMAX(FBMAX)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int checks = 0;
    int errors = 0;
    int pos = -1;
    bit slow = 1'b0;
    int hold_viol = 0;
    logic signed [W-1:0] res [4][CH];
    logic signed [W:0]   obs_mod [4];
    logic signed [W+1:0] obs_sum;
    logic [CHW-1:0]      obs_sum_ch;
    logic                obs_sv;

    task automatic cycle(input logic c);
        bus.cen    = c;
        bus.op_out = (pos >= 0) ? res[pos / CH][pos % CH] : '0;
        @(posedge clk);
        #1;
        if (rst) pos = -1;
        else if (c) pos = (pos + 1) % N;
    endtask

    task automatic tick();
        logic signed [W:0]   s_mod;
        logic signed [W+1:0] s_sum;
        logic [1:0]          s_op;
        logic [CHW-1:0]      s_ch;
        logic                s_v, s_fs, s_sv;
        if (slow) begin
            s_mod = bus.mod_out; s_op = bus.mod_op; s_ch = bus.mod_ch; s_v = bus.mod_valid;
            s_fs = bus.frame_sync; s_sum = bus.ch_sum; s_sv = bus.ch_sum_valid;
            for (int i = 0; i < 2; i++) begin
                cycle(1'b0);
                if (bus.mod_out !== s_mod || bus.mod_op !== s_op || bus.mod_ch !== s_ch ||
                    bus.mod_valid !== s_v || bus.frame_sync !== s_fs || bus.ch_sum !== s_sum ||
                    bus.ch_sum_valid !== s_sv)
                    hold_viol++;
            end
        end
        cycle(1'b1);
    endtask

    task automatic align();
        int g = 0;
        while (pos != N - 1 && g < 2 * N) begin
            tick();
            g++;
        end
        checks++;
        if (pos != N - 1) begin
            errors++;
            $display("FAIL align: position %0d, required %0d", pos, N - 1);
        end
    endtask

    // One full frame from an aligned start; optional config write issued while slot wr_pos is presented.
    task automatic run_frame(input int ch, input int wr_pos, input int wch, input int walg, input int wfb);
        for (int i = 0; i < 4; i++) obs_mod[i] = 'x;
        obs_sum = 'x; obs_sum_ch = 'x; obs_sv = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (pos == wr_pos) begin
                bus.cfg_we = 1'b1; bus.cfg_ch = CHW'(wch);
                bus.cfg_alg = 3'(walg); bus.cfg_fb = 3'(wfb);
            end
            tick();
            bus.cfg_we = 1'b0;
            if (pos % CH == ch) obs_mod[pos / CH] = bus.mod_out;
            if (k == 3 * CH + ch + 1) begin
                obs_sum = bus.ch_sum; obs_sum_ch = bus.ch_sum_ch; obs_sv = bus.ch_sum_valid;
            end
        end
    endtask

    task automatic check_frame(input string name, input int ch, input int em [4], input int es);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs_mod[i] !== em[i]) begin
                errors++;
                $display("FAIL %s mod op%0d: got %0d expected %0d", name, i + 1, obs_mod[i], em[i]);
            end
        end
        checks++;
        if (obs_sv !== 1'b1 || obs_sum !== es || obs_sum_ch !== CHW'(ch)) begin
            errors++;
            $display("FAIL %s ch_sum: got v=%0b %0d ch%0d expected v=1 %0d ch%0d",
                     name, obs_sv, obs_sum, obs_sum_ch, es, ch);
        end
    endtask

    task automatic test_reset();
        bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_alg = '0; bus.cfg_fb = '0;
        for (int o = 0; o < 4; o++) for (int c = 0; c < CH; c++) res[o][c] = '0;
        rst = 1'b1;
        repeat (3) cycle(1'b1);
        checks++;
        if (bus.mod_valid !== 1'b0 || bus.mod_out !== '0 || bus.mod_op !== 2'd0 || bus.mod_ch !== '0 ||
            bus.frame_sync !== 1'b0 || bus.ch_sum !== '0 || bus.ch_sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b mod=%0d op=%0d ch=%0d fs=%0b sum=%0d sv=%0b expected all 0",
                     bus.mod_valid, bus.mod_out, bus.mod_op, bus.mod_ch, bus.frame_sync, bus.ch_sum, bus.ch_sum_valid);
        end
        rst = 1'b0;
    endtask

    task automatic test_schedule();
        for (int s = 0; s < N; s++) begin
            tick();
            checks++;
            if (bus.mod_valid !== 1'b1 || bus.mod_op !== 2'(s / CH) || bus.mod_ch !== CHW'(s % CH) ||
                bus.frame_sync !== (s == 0) || bus.mod_out !== '0) begin
                errors++;
                $display("FAIL schedule slot %0d: got v=%0b op=%0d ch=%0d fs=%0b mod=%0d expected v=1 op=%0d ch=%0d fs=%0b mod=0",
                         s, bus.mod_valid, bus.mod_op, bus.mod_ch, bus.frame_sync, bus.mod_out, s / CH, s % CH, s == 0);
            end
        end
    endtask

    task automatic test_alg0();
        res[0][2] = 100; res[1][2] = 200; res[2][2] = 300; res[3][2] = 400;
        run_frame(2, N - 1, 2, 0, 0);
        check_frame("alg0_ch2", 2, '{0, 100, 200, 300}, 400);
    endtask

    task automatic test_alg7();
        for (int o = 0; o < 4; o++) res[o][0] = -14'sd8192;
        // written on the same edge ch0's op1 latches, so alg7 starts one frame later
        run_frame(0, N - 1, 0, 7, 0);
        check_frame("alg7_latch_edge", 0, '{0, -8192, -8192, -8192}, -8192);
        run_frame(0, -1, 0, 0, 0);
        check_frame("alg7_ch0", 0, '{0, 0, 0, 0}, -32768);
    endtask

    task automatic test_feedback();
        int em [5] = '{0, 250, 750, 11, -8};
        int ov [5] = '{1000, 2000, 1000, -3000, -3000};
        for (int f = 0; f < 5; f++) begin
            res[0][1] = 14'(ov[f]);
            if (f == 0)      run_frame(1, N - 1, 1, 0, 7);
            else if (f == 2) run_frame(1, 2 * CH, 1, 0, 1);
            else             run_frame(1, -1, 0, 0, 0);
            checks++;
            if (obs_mod[0] !== em[f]) begin
                errors++;
                $display("FAIL feedback frame %0d: got %0d expected %0d", f, obs_mod[0], em[f]);
            end
        end
    endtask

    task automatic test_cfg_timing();
        res[0][3] = 11; res[1][3] = 22; res[2][3] = 33; res[3][3] = 44;
        run_frame(3, 2 * CH + 3, 3, 5, 0);
        check_frame("cfg_midframe_old", 3, '{0, 11, 22, 33}, 44);
        run_frame(3, -1, 0, 0, 0);
        check_frame("cfg_next_alg5", 3, '{0, 11, 11, 11}, 99);
    endtask

    task automatic test_cen();
        res[0][4] = 10; res[1][4] = 20; res[2][4] = 30; res[3][4] = 40;
        slow = 1'b0;
        run_frame(4, N - 1, 4, 4, 0);
        check_frame("alg4_full_cen", 4, '{0, 10, 0, 30}, 60);
        slow = 1'b1;
        hold_viol = 0;
        run_frame(4, N - 1, 7, 7, 7);
        check_frame("alg4_slow_cen", 4, '{0, 10, 0, 30}, 60);
        slow = 1'b0;
        checks++;
        if (hold_viol != 0) begin
            errors++;
            $display("FAIL cen_hold: %0d frozen cycles changed outputs, expected 0", hold_viol);
        end
    endtask

    task automatic test_reset_mid();
        int g = 0;
        while (pos != 3 * CH + 2 && g < 2 * N) begin
            tick();
            g++;
        end
        rst = 1'b1;
        cycle(1'b1);
        checks++;
        if (bus.ch_sum_valid !== 1'b0 || bus.ch_sum !== '0 || bus.mod_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got sv=%0b sum=%0d v=%0b expected 0 0 0",
                     bus.ch_sum_valid, bus.ch_sum, bus.mod_valid);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (bus.mod_op !== 2'd0 || bus.mod_ch !== '0 || bus.frame_sync !== 1'b1 ||
            bus.mod_valid !== 1'b1 || bus.ch_sum_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_restart: got op=%0d ch=%0d fs=%0b v=%0b sv=%0b expected 0 0 1 1 0",
                     bus.mod_op, bus.mod_ch, bus.frame_sync, bus.mod_valid, bus.ch_sum_valid);
        end
        for (int o = 0; o < 4; o++) for (int c = 0; c < CH; c++) res[o][c] = '0;
        align();
        run_frame(1, -1, 0, 0, 0);
        checks++;
        if (obs_mod[0] !== 0) begin
            errors++;
            $display("FAIL reset_mid_history: ch1 op1 mod got %0d expected 0", obs_mod[0]);
        end
    endtask

    initial begin
        bus.cen = 1'b0; bus.op_out = '0;
        test_reset();
        test_schedule();
        test_alg0();
        test_alg7();
        test_feedback();
        test_cfg_timing();
        test_cen();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

`default_nettype wire
